// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// Module   : fifo_burst_reader_pkg
// Brief    : Shared state encoding and output-buffer sizing for the burst reader.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package fifo_burst_reader_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int OUT_BUF_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// Module   : stream_skid_buf
// Brief    : 2-entry fall-through FIFO between the FIFO read port and the stream.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module stream_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_mem [OUT_BUF_DEPTH];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    // A word arriving into an empty buffer is presented the same cycle; it is
    // only stored when the consumer does not take it immediately.
    assign rd_valid  = (r_count != 2'd0) || wr_en;
    assign rd_data   = (r_count != 2'd0) ? r_mem[r_head] :
                       (wr_en ? wr_data : '0);
    assign w_bypass  = (r_count == 2'd0) && wr_en && rd_ready;
    assign w_push    = wr_en && !w_bypass;
    assign w_pop     = (r_count != 2'd0) && rd_ready;
    assign occupancy = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// Module   : fifo_burst_reader
// Brief    : Drains fixed-length bursts from a FIFO onto a valid/ready stream.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LEVEL_W   = 9,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [LEVEL_W-1:0] rd_water_level,
    input  logic               rd_empty,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic [CNT_W-1:0]   burst_cnt
);

    localparam int                 REM_W        = $clog2(BURST_LEN + 1);
    localparam logic [REM_W-1:0]   REM_LOAD     = REM_W'(BURST_LEN);
    localparam logic [REM_W-1:0]   REM_ONE      = REM_W'(1);
    localparam logic [LEVEL_W:0]   LEVEL_THRESH = (LEVEL_W + 1)'(BURST_LEN);

    state_t           r_state;
    state_t           w_state_next;
    logic [REM_W-1:0] r_remaining;
    logic             r_inflight;
    logic             r_inflight_last;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [1:0]       w_occupancy;
    logic [DATA_W:0]  w_head;
    logic             w_load;
    logic             w_level_ok;
    logic             w_credit_ok;
    logic             w_last_hs;

    assign w_level_ok  = {1'b0, rd_water_level} >= LEVEL_THRESH;
    // Reads are only issued when the buffer can hold every word already owed to it.
    assign w_credit_ok = (w_occupancy + {1'b0, r_inflight}) < 2'(OUT_BUF_DEPTH);
    assign w_last_hs   = m_valid && m_ready && m_last;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        rd_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_level_ok && (w_occupancy == 2'd0) && !r_inflight) begin
                    w_state_next = BURST;
                    w_load       = 1'b1;
                end
            end
            BURST: begin
                rd_en = (r_remaining != '0) && !rd_empty && w_credit_ok;
                if (w_last_hs) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_burst_cnt     <= '0;
        end else begin
            if (w_load) begin
                r_remaining <= REM_LOAD;
            end else if (rd_en) begin
                r_remaining <= r_remaining - REM_ONE;
            end
            r_inflight      <= rd_en;
            r_inflight_last <= rd_en && (r_remaining == REM_ONE);
            if (w_last_hs) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (DATA_W + 1)
    ) u_out_buf (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .wr_en     (r_inflight),
        .wr_data   ({r_inflight_last, rd_data}),
        .rd_valid  (m_valid),
        .rd_data   (w_head),
        .rd_ready  (m_ready),
        .occupancy (w_occupancy)
    );

    assign m_data    = w_head[DATA_W-1:0];
    assign m_last    = w_head[DATA_W];
    assign busy      = (r_state == BURST);
    assign burst_cnt = r_burst_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// Module   : tb_fifo_burst_reader
// Brief    : Self-checking bench with a FIFO model and an in-order stream scoreboard.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_burst_reader;

    localparam int DATA_W    = 8;
    localparam int LEVEL_W   = 9;
    localparam int BURST_LEN = 16;
    localparam int CNT_W     = 16;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic [LEVEL_W-1:0] rd_water_level;
    logic               rd_empty;
    logic               rd_en;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  m_data;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic               m_last;
    logic               busy;
    logic [CNT_W-1:0]   burst_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W-1:0] exp_q  [$];
    logic              wr_req      = 1'b0;
    logic [DATA_W-1:0] wr_word     = '0;
    logic              force_empty = 1'b0;
    int                pending     = 0;
    int                hs_total    = 0;
    int                exp_bursts  = 0;
    int                beat_idx    = 0;
    int                ready_mode  = 0;
    int                cyc         = 0;
    logic              prev_stall  = 1'b0;
    logic [DATA_W-1:0] prev_data   = '0;
    logic              prev_last   = 1'b0;
    logic [DATA_W-1:0] exp_word;

    typedef struct {
        int n_words;
        int mode;
        int exp_bursts;
        int exp_level;
    } vec_t;
    vec_t vecs [6];

    always #5 sys_clk = ~sys_clk;

    fifo_burst_reader #(
        .DATA_W    (DATA_W),
        .LEVEL_W   (LEVEL_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .rd_water_level (rd_water_level),
        .rd_empty       (rd_empty),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .burst_cnt      (burst_cnt)
    );

    assign rd_empty = (rd_water_level == '0) || force_empty;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // FIFO read side: one-cycle read latency, cleared by the shared reset.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fifo_q.delete();
            exp_q.delete();
            rd_water_level <= '0;
            rd_data        <= '0;
            pending        <= 0;
        end else begin
            if (rd_en && fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
            if (wr_req) begin
                fifo_q.push_back(wr_word);
                exp_q.push_back(wr_word);
            end
            rd_water_level <= LEVEL_W'(fifo_q.size());
            pending <= pending + (rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    always @(posedge sys_clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 3) == 0);
            default: m_ready = ($urandom_range(0, 1) == 1);
        endcase
        cyc = cyc + 1;
    end

    // Stream scoreboard: words leave in write order, every BURST_LEN-th one tagged last.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            beat_idx   = 0;
            exp_bursts = 0;
            prev_stall = 1'b0;
        end else begin
            chk(!(rd_en && rd_empty), "rd_en_while_empty", rd_en, 0);
            chk(!(rd_en && !busy), "rd_en_while_idle", rd_en, 0);
            chk(!rd_en || pending < 2, "read_ahead_credit", pending, 1);
            chk(m_valid == (pending > 0), "valid_vs_pending", m_valid, pending > 0);
            chk(burst_cnt == CNT_W'(exp_bursts), "burst_cnt", burst_cnt, exp_bursts);
            if (prev_stall) begin
                chk(m_valid == 1'b1, "stall_valid", m_valid, 1);
                chk(m_data == prev_data, "stall_data", m_data, prev_data);
                chk(m_last == prev_last, "stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word", m_data, -1);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk(m_data == exp_word, "stream_data", m_data, exp_word);
                end
                chk(m_last == (beat_idx == BURST_LEN - 1), "stream_last", m_last,
                    beat_idx == BURST_LEN - 1);
                if (beat_idx == BURST_LEN - 1) begin
                    beat_idx = 0;
                    exp_bursts++;
                end else begin
                    beat_idx++;
                end
                hs_total++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic do_reset();
        wr_req = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        force_empty = 1'b0;
        @(negedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] w);
        @(negedge sys_clk);
        wr_req  = 1'b1;
        wr_word = w;
    endtask

    task automatic end_write();
        @(negedge sys_clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input int limit);
        int n = 0;
        while (!(burst_cnt == CNT_W'(target) && !busy) && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        chk(n < limit, "burst_wait_timeout", n, limit);
    endtask

    task automatic wait_handshakes(input int count, input int limit);
        int base = hs_total;
        int n    = 0;
        while (hs_total < base + count && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        chk(n < limit, "handshake_wait_timeout", n, limit);
    endtask

    initial begin
        int seen;
        vecs[0] = '{n_words: 16, mode: 0, exp_bursts: 1, exp_level: 0};
        vecs[1] = '{n_words: 16, mode: 1, exp_bursts: 1, exp_level: 0};
        vecs[2] = '{n_words: 40, mode: 0, exp_bursts: 2, exp_level: 8};
        vecs[3] = '{n_words: 33, mode: 2, exp_bursts: 2, exp_level: 1};
        vecs[4] = '{n_words: 15, mode: 0, exp_bursts: 0, exp_level: 15};
        vecs[5] = '{n_words: 48, mode: 2, exp_bursts: 3, exp_level: 0};

        @(negedge sys_clk);
        chk(rd_en == 1'b0, "reset_rd_en", rd_en, 0);
        chk(m_valid == 1'b0, "reset_m_valid", m_valid, 0);
        chk(m_data == '0, "reset_m_data", m_data, 0);
        chk(m_last == 1'b0, "reset_m_last", m_last, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(burst_cnt == '0, "reset_burst_cnt", burst_cnt, 0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Threshold edge and back-to-back timing of a single burst.
        ready_mode = 0;
        for (int i = 0; i < 15; i++) write_word(DATA_W'(i));
        end_write();
        seen = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (rd_en || busy) seen = 1;
        end
        chk(seen == 0, "below_threshold_idle", seen, 0);
        chk(rd_water_level == 9'd15, "level_15", rd_water_level, 15);
        write_word(8'h0F);
        end_write();
        chk(rd_water_level == 9'd16, "level_16", rd_water_level, 16);
        chk(busy == 1'b0, "busy_at_level_edge", busy, 0);
        @(negedge sys_clk);
        chk(busy == 1'b1, "start_busy", busy, 1);
        chk(rd_en == 1'b1, "start_rd_en", rd_en, 1);
        for (int i = 0; i < BURST_LEN; i++) begin
            @(negedge sys_clk);
            chk(m_valid == 1'b1, "stream_consecutive", m_valid, 1);
            chk(m_data == DATA_W'(i), "stream_value", m_data, i);
            chk(m_last == (i == BURST_LEN - 1), "stream_last_pos", m_last, i == BURST_LEN - 1);
        end
        @(negedge sys_clk);
        chk(busy == 1'b0, "busy_after_burst", busy, 0);
        chk(burst_cnt == 16'd1, "one_burst", burst_cnt, 1);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            ready_mode = vecs[v].mode;
            for (int i = 0; i < vecs[v].n_words; i++) write_word(DATA_W'($urandom));
            end_write();
            wait_bursts(vecs[v].exp_bursts, 3000);
            repeat (20) @(negedge sys_clk);
            chk(burst_cnt == CNT_W'(vecs[v].exp_bursts), "vec_bursts", burst_cnt, vecs[v].exp_bursts);
            chk(rd_water_level == LEVEL_W'(vecs[v].exp_level), "vec_level", rd_water_level,
                vecs[v].exp_level);
            chk(busy == 1'b0, "vec_idle", busy, 0);
            chk(m_valid == 1'b0, "vec_drained", m_valid, 0);
        end

        // FIFO empty forced for three cycles in the middle of a burst.
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 16; i++) write_word(DATA_W'(8'h30 + i));
        end_write();
        wait_handshakes(4, 200);
        @(posedge sys_clk);
        #1 force_empty = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            chk(rd_en == 1'b0, "paused_rd_en", rd_en, 0);
        end
        @(posedge sys_clk);
        #1 force_empty = 1'b0;
        wait_bursts(1, 500);
        chk(rd_water_level == '0, "pause_level", rd_water_level, 0);

        // Reset in the middle of a burst, then a fresh burst.
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 16; i++) write_word(DATA_W'(8'hA0 + i));
        end_write();
        wait_handshakes(5, 200);
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        #1;
        chk(rd_en == 1'b0, "midrst_rd_en", rd_en, 0);
        chk(m_valid == 1'b0, "midrst_m_valid", m_valid, 0);
        chk(m_data == '0, "midrst_m_data", m_data, 0);
        chk(m_last == 1'b0, "midrst_m_last", m_last, 0);
        chk(busy == 1'b0, "midrst_busy", busy, 0);
        chk(burst_cnt == '0, "midrst_burst_cnt", burst_cnt, 0);
        @(negedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        for (int i = 0; i < 16; i++) write_word(DATA_W'(8'h50 + i));
        end_write();
        wait_bursts(1, 500);
        chk(burst_cnt == 16'd1, "post_reset_burst", burst_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
